// File: rtl/frame_sequencer.sv
// frame_sequencer: prescaled step sequencer emitting quarter/half-frame pulses.
// Define FRAME_IRQ_EN to build the frame-interrupt flag (irq tied low otherwise).
module frame_sequencer #(
    parameter int CLKRATE    = 1_790_000,
    parameter int STEPRATE   = 240,
    parameter int PRESCALE_W = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_wr,
    input  logic       mode_5step,
    input  logic       irq_inhibit,
    input  logic       irq_ack,
    output logic       quarter_en,
    output logic       half_en,
    output logic [2:0] step,
    output logic       irq
);
    localparam int PRESCALE = CLKRATE / STEPRATE;
    localparam logic [PRESCALE_W-1:0] RELOAD = PRESCALE_W'(PRESCALE - 1);

    generate
        if (PRESCALE < 2 || PRESCALE > (1 << PRESCALE_W)) begin : g_bad_prescale
            $error("frame_sequencer: PRESCALE out of range");
        end
    endgenerate

    logic [PRESCALE_W-1:0] r_presc;
    logic [2:0]            r_step;
    logic                  r_mode;
    logic                  r_quarter;
    logic                  r_half;

    logic                  w_tick;
    logic [2:0]            w_step_nxt;
    logic                  w_q_sel;
    logic                  w_h_sel;

    assign w_tick = (r_presc == '0);

    always_comb begin
        w_step_nxt = r_step + 3'd1;
        w_q_sel    = 1'b0;
        w_h_sel    = 1'b0;
        if ((r_mode && r_step == 3'd4) || (!r_mode && r_step == 3'd3)) begin
            w_step_nxt = 3'd0;
        end
        // step 3 pulses only in 4-step mode, step 4 only exists in 5-step mode
        case (r_step)
            3'd0: begin
                w_q_sel = 1'b1;
            end
            3'd1: begin
                w_q_sel = 1'b1;
                w_h_sel = 1'b1;
            end
            3'd2: begin
                w_q_sel = 1'b1;
            end
            3'd3: begin
                w_q_sel = !r_mode;
                w_h_sel = !r_mode;
            end
            3'd4: begin
                w_q_sel = r_mode;
                w_h_sel = r_mode;
            end
            default: begin
                w_q_sel = 1'b0;
                w_h_sel = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= RELOAD;
            r_step    <= 3'd0;
            r_mode    <= 1'b0;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
        end else if (mode_wr) begin
            r_presc   <= RELOAD;
            r_step    <= 3'd0;
            r_mode    <= mode_5step;
            r_quarter <= mode_5step;
            r_half    <= mode_5step;
        end else begin
            r_presc   <= w_tick ? RELOAD : r_presc - 1'b1;
            r_quarter <= w_tick & w_q_sel;
            r_half    <= w_tick & w_h_sel;
            if (w_tick) begin
                r_step <= w_step_nxt;
            end
        end
    end

    assign quarter_en = r_quarter;
    assign half_en    = r_half;
    assign step       = r_step;

`ifdef FRAME_IRQ_EN
    logic r_inhibit;
    logic r_irq;
    logic w_irq_set;
    logic w_irq_clr;

    // a mode write discards a coincident tick, so it can never set the flag
    assign w_irq_set = w_tick && !mode_wr && !r_mode
                       && (r_step == 3'd3) && !r_inhibit;
    assign w_irq_clr = irq_ack || (mode_wr && irq_inhibit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inhibit <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (mode_wr) begin
                r_inhibit <= irq_inhibit;
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign irq = r_irq;
`else
    logic w_unused;

    assign w_unused = irq_ack ^ irq_inhibit;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed vector table, reset/IRQ corner sequences,
// and randomized traffic compared against a step-rule reference model.
module tb_frame_sequencer;
    localparam int P = 10;
`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_wr = 1'b0;
    logic       mode_5step = 1'b0;
    logic       irq_inhibit = 1'b0;
    logic       irq_ack = 1'b0;
    logic       quarter_en;
    logic       half_en;
    logic [2:0] step;
    logic       irq;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_sequencer #(
        .CLKRATE   (2400),
        .STEPRATE  (240),
        .PRESCALE_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_wr    (mode_wr),
        .mode_5step (mode_5step),
        .irq_inhibit(irq_inhibit),
        .irq_ack    (irq_ack),
        .quarter_en (quarter_en),
        .half_en    (half_en),
        .step       (step),
        .irq        (irq)
    );

    // Reference: edges since last reload, tick on every P-th edge.
    int m_cnt;
    int m_step;
    bit m_mode;
    bit m_inh;
    bit m_q;
    bit m_h;
    bit m_irq;

    function automatic bit q_of(bit m5, int s);
        return m5 ? (s != 3) : 1'b1;
    endfunction

    function automatic bit h_of(bit m5, int s);
        return m5 ? (s == 1 || s == 4) : (s == 1 || s == 3);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_step <= 0;
            m_mode <= 1'b0;
            m_inh  <= 1'b0;
            m_q    <= 1'b0;
            m_h    <= 1'b0;
            m_irq  <= 1'b0;
        end else if (mode_wr) begin
            m_cnt  <= 0;
            m_step <= 0;
            m_mode <= mode_5step;
            m_inh  <= irq_inhibit;
            m_q    <= mode_5step;
            m_h    <= mode_5step;
            if (IRQ_EN && (irq_ack || irq_inhibit)) m_irq <= 1'b0;
        end else if (m_cnt + 1 == P) begin
            m_cnt  <= 0;
            m_step <= (m_step + 1) % (m_mode ? 5 : 4);
            m_q    <= q_of(m_mode, m_step);
            m_h    <= h_of(m_mode, m_step);
            if (IRQ_EN && !m_mode && m_step == 3 && !m_inh) m_irq <= 1'b1;
            else if (IRQ_EN && irq_ack) m_irq <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            m_q   <= 1'b0;
            m_h   <= 1'b0;
            if (IRQ_EN && irq_ack) m_irq <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        bit wr;
        bit m5;
        int adv;
        int st;
        bit q;
        bit h;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{0, 0, 0,  0, 0, 0};
        tbl[1]  = '{0, 0, 9,  0, 0, 0};
        tbl[2]  = '{0, 0, 1,  1, 1, 0};
        tbl[3]  = '{0, 0, 1,  1, 0, 0};
        tbl[4]  = '{0, 0, 9,  2, 1, 1};
        tbl[5]  = '{0, 0, 10, 3, 1, 0};
        tbl[6]  = '{0, 0, 10, 0, 1, 1};
        tbl[7]  = '{0, 0, 10, 1, 1, 0};
        tbl[8]  = '{1, 1, 1,  0, 1, 1};
        tbl[9]  = '{0, 0, 1,  0, 0, 0};
        tbl[10] = '{0, 0, 9,  1, 1, 0};
        tbl[11] = '{0, 0, 10, 2, 1, 1};
        tbl[12] = '{0, 0, 10, 3, 1, 0};
        tbl[13] = '{0, 0, 10, 4, 0, 0};
        tbl[14] = '{0, 0, 10, 0, 1, 1};
        tbl[15] = '{0, 0, 9,  0, 0, 0};
        tbl[16] = '{1, 0, 1,  0, 0, 0};
        tbl[17] = '{0, 0, 9,  0, 0, 0};
        tbl[18] = '{0, 0, 1,  1, 1, 0};

        adv(2);
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) begin
                mode_wr    = 1'b1;
                mode_5step = tbl[i].m5;
                adv(1);
                mode_wr    = 1'b0;
                mode_5step = ~tbl[i].m5;
                adv(tbl[i].adv - 1);
            end else begin
                adv(tbl[i].adv);
            end
            chk($sformatf("vec%0d_step", i), step, tbl[i].st);
            chk($sformatf("vec%0d_quarter", i), quarter_en, tbl[i].q);
            chk($sformatf("vec%0d_half", i), half_en, tbl[i].h);
            chk($sformatf("vec%0d_irq", i), irq, m_irq);
        end

        // asynchronous reset in the middle of step 2
        adv(15);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_quarter", quarter_en, 0);
        chk("arst_half", half_en, 0);
        chk("arst_step", step, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        adv(9);
        chk("rel_noq", quarter_en, 0);
        adv(1);
        chk("rel_q", quarter_en, 1);
        chk("rel_step", step, 1);

`ifdef FRAME_IRQ_EN
        adv(29);
        chk("irq_before", irq, 0);
        adv(1);
        chk("irq_set", irq, 1);
        irq_ack = 1'b1;
        adv(1);
        irq_ack = 1'b0;
        chk("irq_ack", irq, 0);
        adv(38);
        irq_ack = 1'b1;
        adv(1);
        irq_ack = 1'b0;
        chk("irq_ack_vs_set", irq, 1);
        mode_wr     = 1'b1;
        irq_inhibit = 1'b1;
        mode_5step  = 1'b0;
        adv(1);
        mode_wr     = 1'b0;
        irq_inhibit = 1'b0;
        chk("irq_inh_clr", irq, 0);
`else
        for (int i = 0; i < 100; i++) begin
            irq_ack = ~irq_ack;
            adv(1);
            chk("irq_off", irq, 0);
        end
        irq_ack = 1'b0;
`endif

        rst_n = 1'b0;
        adv(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            chk("rnd_step", step, m_step);
            chk("rnd_quarter", quarter_en, m_q);
            chk("rnd_half", half_en, m_h);
            chk("rnd_irq", irq, m_irq);
            mode_wr     = ($urandom_range(59) == 0);
            mode_5step  = $urandom_range(1) == 1;
            irq_inhibit = $urandom_range(3) == 0;
            irq_ack     = $urandom_range(7) == 0;
            adv(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
